mips_fetch: RTL and testbench
=============================

# mips_fetch

Instruction fetch unit for the single-cycle-decode MIPS datapath. Holds the PC, requests instruction words from instruction memory over a req/ack handshake, and presents the fetched word in an instruction register whose `inst[31:26]` field drives the `Control` decoder. It consumes `Jump`/`Branch` back from `Control` and `zero` from the ALU to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  byte address of requested word, stable while `imem_req`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`
- `inst`  out  32  instruction register; `inst[31:26]` to `Control`
- `inst_valid`  out  1  `inst`/`pc_out` hold a fetched instruction
- `inst_ready`  in  1  downstream accepts `inst` this cycle
- `pc_out`  out  32  address of `inst`
- `pc_plus4`  out  32  `pc_out + 4`, mod 2^32
- `Jump`  in  1  from `Control`, decoded from current `inst`
- `Branch`  in  1  from `Control`, decoded from current `inst`
- `zero`  in  1  ALU zero flag for current `inst`
- `fetch_count`  out  32  accepted-instruction counter (see Configuration)

## Operation
- FSM states: `RST` -> `REQ` -> `HOLD` -> `REQ` ...
- `RST`: entered on `rst`; PC = `RESET_PC`. Leaves unconditionally one cycle after `rst` deasserts.
- `REQ`: `imem_req`=1, `imem_addr`=PC. On `imem_ack`: `inst` <= `imem_rdata`, `pc_out` <= PC, go `HOLD`. No ack: stay, address unchanged.
- `HOLD`: `inst_valid`=1, `imem_req`=0. On `inst_ready`: PC <= next PC, go `REQ`. Otherwise hold `inst`/`pc_out` stable.
- Next PC, evaluated combinationally in the accept cycle, priority order:
  - `Jump`: `{pc_plus4[31:28], inst[25:0], 2'b00}`
  - `Branch & zero`: `pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}`, mod 2^32
  - else `pc_plus4`
- `Jump` and `Branch` both high: `Jump` wins.
- No delay slot; PC arithmetic wraps silently (32'hFFFF_FFFC + 4 = 0).
- `imem_ack` outside `REQ` is ignored; `inst_ready` outside `HOLD` is ignored.
- `Jump`/`Branch`/`zero` are sampled only on accept; values in other cycles are don't-care.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst`=0, `inst_valid`=0, `pc_out`=`RESET_PC`, `pc_plus4`=`RESET_PC+4`, `fetch_count`=0.
- `rst` asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge. Any outstanding request is abandoned, and an ack in the first `REQ` cycle after reset belongs to the new request.
- First `imem_req` occurs in the 2nd rising edge after `rst` deasserts (1 cycle in `RST`).
- Zero-wait memory (ack in same cycle as req): `inst_valid` rises 1 cycle after req. With `inst_ready` tied 1, throughput is 1 instruction per 2 cycles.
- New `imem_req` appears the cycle after the accept, carrying the next PC.
- All outputs registered except `pc_plus4`, which is combinational from `pc_out`.

## Configuration
- `MIPS_FETCH_COUNT_EN` defined: `fetch_count` increments by 1 on every accept (`HOLD & inst_ready`), wraps at 2^32, and is cleared by `rst`.
- Not defined: `fetch_count` tied to 0 and no counter flops are generated. Port present either way.

## Test plan
- Reset with `RESET_PC`=0, ack tied 1, ready tied 1, opcodes 000000 (R-type) -> `imem_addr` sequence 0x0, 0x4, 0x8, one request every 2 cycles.
- `inst`=0x08000010 (j), `Jump`=1 at `pc_out`=0x0000_0040 -> next `imem_addr`=0x0000_0040.
- beq at 0x100, imm 0xFFFF, `Branch`=1, `zero`=1 -> next addr 0x100. Same with `zero`=0 -> 0x104.
- `imem_ack` delayed 3 cycles, then `inst_ready` held 0 for 4 cycles -> `imem_addr` stable for 4 req cycles, `inst`/`pc_out` stable, no new req until accept.
- `rst` pulsed while in `HOLD` at PC 0x20 -> `inst_valid` drops without a clock edge. Next request goes to `RESET_PC`, and `fetch_count`=0.
- PC 0xFFFF_FFFC, no branch -> next `imem_addr`=0x0. With `MIPS_FETCH_COUNT_EN`, 5 accepts -> `fetch_count`=5.

Source files
------------

// File: rtl/mips_fetch.sv
// Instruction fetch unit: PC register, req/ack fetch from instruction memory, and an
// instruction register with jump/branch next-PC selection. Optional counter: `MIPS_FETCH_COUNT_EN.
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        zero,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] branch_off;
    logic [31:0] jump_tgt;
    logic [31:0] next_pc;
    logic        accept;

    assign pc_plus4   = pc_out_q + 32'd4;
    assign branch_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    assign jump_tgt   = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    assign accept     = (state_q == ST_HOLD) && inst_ready;

    // Jump outranks a taken branch; no delay slot, so the target follows the current inst.
    always_comb begin
        if (Jump) begin
            next_pc = jump_tgt;
        end else if (Branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold-value default before the case, so no path leaves
        // a signal unassigned and no latch is inferred.
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        case (state_q)
            ST_RST: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    inst_d   = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    // NOTE: state flops use non-blocking assignments and an asynchronous reset, so
    // outputs return to reset values the moment rst rises, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RST;
            pc_q     <= RESET_PC;
            inst_q   <= 32'h0;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_req   = (state_q == ST_REQ);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == ST_HOLD);
    assign pc_out     = pc_out_q;

`ifdef MIPS_FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (accept) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: directed scenarios plus random memory/downstream
// timing, compared against a transaction-level model of the fetch protocol.
module tb_mips_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        Jump;
    logic        Branch;
    logic        zero;
    logic [31:0] fetch_count;

    mips_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .Jump       (Jump),
        .Branch     (Branch),
        .zero       (zero),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the fetch unit should be presenting right now.
    logic        m_rst_wait;
    logic        m_have;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc_out;
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef MIPS_FETCH_COUNT_EN
        return m_count;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] w,
                                                  input logic j, input logic b, input logic z);
        logic [31:0] p4;
        int          off;
        p4 = pc + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
        if (b && z) begin
            off = $signed(w[15:0]) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic model_reset();
        m_rst_wait = 1'b1;
        m_have     = 1'b0;
        m_pc       = 32'h0;
        m_inst     = 32'h0;
        m_pc_out   = 32'h0;
        m_count    = 32'h0;
    endtask

    // Called at a falling edge: check outputs, drive inputs for the next rising edge,
    // advance the model, move to the next falling edge.
    task automatic step(input logic ack, input logic [31:0] rdata, input logic rdy,
                        input logic j, input logic b, input logic z);
        logic exp_req;
        exp_req = !m_rst_wait && !m_have;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("inst_valid", 32'(inst_valid), 32'(m_have));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("inst", inst, m_inst);
        check("pc_out", pc_out, m_pc_out);
        check("pc_plus4", pc_plus4, m_pc_out + 32'd4);
        check("fetch_count", fetch_count, exp_count());
        imem_ack   = ack;
        imem_rdata = rdata;
        inst_ready = rdy;
        Jump       = j;
        Branch     = b;
        zero       = z;
        if (m_rst_wait) begin
            m_rst_wait = 1'b0;
        end else if (!m_have) begin
            if (ack) begin
                m_have   = 1'b1;
                m_inst   = rdata;
                m_pc_out = m_pc;
            end
        end else if (rdy) begin
            m_pc    = model_next_pc(m_pc_out, m_inst, j, b, z);
            m_have  = 1'b0;
            m_count = m_count + 32'd1;
        end
        @(negedge clk);
    endtask

    // From a request cycle: zero-wait fetch of one word, then accept it.
    task automatic fetch(input logic [31:0] w, input logic j, input logic b, input logic z);
        step(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, j, b, z);
    endtask

    // Raise rst between clock edges and check outputs before any edge arrives.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("arst_inst_valid", 32'(inst_valid), 32'h0);
        check("arst_imem_req", 32'(imem_req), 32'h0);
        check("arst_imem_addr", imem_addr, 32'h0);
        check("arst_inst", inst, 32'h0);
        check("arst_pc_out", pc_out, 32'h0);
        check("arst_pc_plus4", pc_plus4, 32'h4);
        check("arst_fetch_count", fetch_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        Jump       = 1'b0;
        Branch     = 1'b0;
        zero       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        rst = 1'b0;

        // One cycle in reset state; ack/ready there must be ignored.
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);

        // ack and ready tied high: R-type stream at 0, 4, 8.
        check("seq_addr0", imem_addr, 32'h0);
        repeat (2) step(1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0);
        check("seq_addr4", imem_addr, 32'h4);
        repeat (2) step(1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0);
        check("seq_addr8", imem_addr, 32'h8);

        fetch(32'h0800_0010, 1'b1, 1'b0, 1'b0);
        check("jump_to_40", imem_addr, 32'h40);
        fetch(32'h0800_0010, 1'b1, 1'b0, 1'b0);
        check("jump_at_40", imem_addr, 32'h40);
        fetch(32'h0800_0040, 1'b1, 1'b1, 1'b1);
        check("jump_over_branch", imem_addr, 32'h100);
        fetch(32'h1000_FFFF, 1'b0, 1'b1, 1'b1);
        check("beq_taken", imem_addr, 32'h100);
        fetch(32'h1000_FFFF, 1'b0, 1'b1, 1'b0);
        check("beq_not_taken", imem_addr, 32'h104);

        // Slow memory, then a stalled consumer.
        repeat (3) begin
            step(1'b0, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
            check("stall_addr", imem_addr, 32'h104);
        end
        step(1'b1, 32'h2108_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            step(1'b1, $urandom, 1'b0, 1'b1, 1'b1, 1'b1);
            check("stall_inst", inst, 32'h2108_0001);
            check("stall_pc_out", pc_out, 32'h104);
            check("stall_no_req", 32'(imem_req), 32'h0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_stall", imem_addr, 32'h108);

        // Reach the top of the address space, then wrap.
        fetch(32'h1000_8000, 1'b0, 1'b1, 1'b1);
        check("branch_back", imem_addr, 32'hFFFE_010C);
        fetch(32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0);
        check("jump_top", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        check("pc_wrap", imem_addr, 32'h0);

        // Reset while holding the instruction at 0x20.
        fetch(32'h0800_0008, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h8C00_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_pc_out", pc_out, 32'h20);
        async_reset();
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_addr", imem_addr, 32'h0);
        repeat (5) fetch(32'h0000_0020, 1'b0, 1'b0, 1'b0);
`ifdef MIPS_FETCH_COUNT_EN
        check("count_5", fetch_count, 32'd5);
`else
        check("count_off", fetch_count, 32'd0);
`endif

        // Random memory latency, consumer backpressure and control inputs.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
